// File: rtl/lb_pkg.sv
// Shared definitions for the local-bus serial link: default frame width,
// bit-order selectors and the receive-side state encoding.
package lb_pkg;

    localparam int LB_RX_DATA_W_DEF = 12;

    localparam bit LB_LSB_FIRST = 1'b0;
    localparam bit LB_MSB_FIRST = 1'b1;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_e;

endpackage

// File: rtl/lb_deser_rx_if.sv
// Bus bundle between the serial receive deserialiser and its consumer.
// The master drives the serial stream and the acknowledge; the slave is the deserialiser.
interface lb_deser_rx_if #(
    parameter int DATA_W = lb_pkg::LB_RX_DATA_W_DEF
);
    localparam int CNT_W = $clog2(DATA_W);

    logic              data_in;
    logic              shift;
    logic              clear;
    logic              data_ack;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              busy;
    logic [CNT_W-1:0]  bit_cnt;
    logic              overrun;

    modport master (
        output data_in, shift, clear, data_ack,
        input  data_out, data_valid, busy, bit_cnt, overrun
    );

    modport slave (
        input  data_in, shift, clear, data_ack,
        output data_out, data_valid, busy, bit_cnt, overrun
    );

endinterface

// File: rtl/lb_shift_core.sv
// Parametrised shift register with strobe and synchronous clear, usable for
// either bit order. Exposes the post-shift value so callers can capture it on the same edge.
module lb_shift_core
    import lb_pkg::*;
#(
    parameter int DATA_W    = LB_RX_DATA_W_DEF,
    parameter bit MSB_FIRST = LB_LSB_FIRST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift,
    input  logic              clear,
    input  logic              data_in,
    output logic [DATA_W-1:0] shreg_nxt
);

    logic [DATA_W-1:0] shreg;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shreg_nxt = {shreg[DATA_W-2:0], data_in};
        end else begin : g_lsb_first
            assign shreg_nxt = {data_in, shreg[DATA_W-1:1]};
        end
    endgenerate

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
        end else if (clear) begin
            shreg <= '0;
        end else if (shift) begin
            shreg <= shreg_nxt;
        end
    end

endmodule

// File: rtl/lb_deser_rx.sv
// Serial-to-parallel receive deserialiser: counts strobed bits into frames and
// offers each completed frame over a valid/ack handshake with sticky overrun.
module lb_deser_rx
    import lb_pkg::*;
#(
    parameter int DATA_W    = LB_RX_DATA_W_DEF,
    parameter bit MSB_FIRST = LB_LSB_FIRST
) (
    input logic          clk,
    input logic          reset,
    lb_deser_rx_if.slave bus
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] shreg_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic              frame_done;
    rx_state_e         state;

    lb_shift_core #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_core (
        .clk       (clk),
        .reset     (reset),
        .shift     (bus.shift),
        .clear     (bus.clear),
        .data_in   (bus.data_in),
        .shreg_nxt (shreg_nxt)
    );

    // The bit counter is the state: zero is IDLE, anything else is RECV.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        bit_cnt_nxt = bit_cnt;
        frame_done  = 1'b0;
        if (bus.clear) begin
            bit_cnt_nxt = '0;
        end else if (bus.shift) begin
            if (bit_cnt == LAST_BIT) begin
                bit_cnt_nxt = '0;
                frame_done  = 1'b1;
            end else begin
                bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state       = (bit_cnt == '0) ? RX_IDLE : RX_RECV;
        bus.busy    = (state == RX_RECV);
        bus.bit_cnt = bit_cnt;
    end

    // A completing frame always wins over an ack, so the newest word stays offered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            if (frame_done) begin
                bus.data_out <= shreg_nxt;
            end

            if (frame_done) begin
                bus.data_valid <= 1'b1;
            end else if (bus.data_ack) begin
                bus.data_valid <= 1'b0;
            end

            if (bus.clear) begin
                bus.overrun <= 1'b0;
            end else if (frame_done && bus.data_valid && !bus.data_ack) begin
                bus.overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lb_deser_rx.sv
// Bench for lb_deser_rx: four instances (12 LSB, 12 MSB, 8 LSB, 2 MSB) share one
// serial stream; a frame-level model feeds a scoreboard checked by a negedge monitor.
module tb_lb_deser_rx;
    import lb_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic data_in;
    logic shift;
    logic clear;
    logic data_ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lb_deser_rx_if #(.DATA_W(12)) if0 ();
    lb_deser_rx_if #(.DATA_W(12)) if1 ();
    lb_deser_rx_if #(.DATA_W(8))  if2 ();
    lb_deser_rx_if #(.DATA_W(2))  if3 ();

    assign if0.data_in = data_in;  assign if0.shift = shift;
    assign if0.clear   = clear;    assign if0.data_ack = data_ack;
    assign if1.data_in = data_in;  assign if1.shift = shift;
    assign if1.clear   = clear;    assign if1.data_ack = data_ack;
    assign if2.data_in = data_in;  assign if2.shift = shift;
    assign if2.clear   = clear;    assign if2.data_ack = data_ack;
    assign if3.data_in = data_in;  assign if3.shift = shift;
    assign if3.clear   = clear;    assign if3.data_ack = data_ack;

    lb_deser_rx #(.DATA_W(12), .MSB_FIRST(LB_LSB_FIRST)) u_dut0 (.clk(clk), .reset(rst_n), .bus(if0.slave));
    lb_deser_rx #(.DATA_W(12), .MSB_FIRST(LB_MSB_FIRST)) u_dut1 (.clk(clk), .reset(rst_n), .bus(if1.slave));
    lb_deser_rx #(.DATA_W(8),  .MSB_FIRST(LB_LSB_FIRST)) u_dut2 (.clk(clk), .reset(rst_n), .bus(if2.slave));
    lb_deser_rx #(.DATA_W(2),  .MSB_FIRST(LB_MSB_FIRST)) u_dut3 (.clk(clk), .reset(rst_n), .bus(if3.slave));

    logic [31:0] dout  [N];
    logic [31:0] cnt   [N];
    logic        valid [N];
    logic        busy  [N];
    logic        ovr   [N];

    assign dout[0] = 32'(if0.data_out); assign cnt[0] = 32'(if0.bit_cnt);
    assign dout[1] = 32'(if1.data_out); assign cnt[1] = 32'(if1.bit_cnt);
    assign dout[2] = 32'(if2.data_out); assign cnt[2] = 32'(if2.bit_cnt);
    assign dout[3] = 32'(if3.data_out); assign cnt[3] = 32'(if3.bit_cnt);
    assign valid[0] = if0.data_valid; assign busy[0] = if0.busy; assign ovr[0] = if0.overrun;
    assign valid[1] = if1.data_valid; assign busy[1] = if1.busy; assign ovr[1] = if1.overrun;
    assign valid[2] = if2.data_valid; assign busy[2] = if2.busy; assign ovr[2] = if2.overrun;
    assign valid[3] = if3.data_valid; assign busy[3] = if3.busy; assign ovr[3] = if3.overrun;

    function automatic int width_of(input int k);
        case (k)
            0, 1:    return 12;
            2:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic bit msb_of(input int k);
        return (k == 1) || (k == 3);
    endfunction

    // Arrival-ordered bits -> parallel word, according to the instance's bit order.
    function automatic logic [31:0] frame_word(input logic [31:0] bits, input int w, input bit msb);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            if (msb) r[w-1-i] = bits[i];
            else     r[i]     = bits[i];
        end
        return r;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [dut%0d] at %0t: got 0x%0h expected 0x%0h", name, k, $time, act, exp);
        end
    endtask

    // Frame-level reference: bits collected in arrival order, word formed once w bits are in.
    int          nbits   [N];
    logic [31:0] acc     [N];
    logic [31:0] held    [N];
    bit          m_valid [N];
    bit          m_ovr   [N];
    logic [31:0] exp_q   [N][$];

    bit          was_valid;
    logic [31:0] word;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                nbits[k] = 0;  acc[k] = '0;  held[k] = '0;
                m_valid[k] = 1'b0;  m_ovr[k] = 1'b0;
                exp_q[k].delete();
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                was_valid = m_valid[k];
                if (was_valid && data_ack) m_valid[k] = 1'b0;
                if (clear) begin
                    nbits[k] = 0;  acc[k] = '0;  m_ovr[k] = 1'b0;
                end else if (shift) begin
                    acc[k][nbits[k]] = data_in;
                    nbits[k]++;
                    if (nbits[k] == width_of(k)) begin
                        word = frame_word(acc[k], width_of(k), msb_of(k));
                        if (was_valid && !data_ack) begin
                            m_ovr[k] = 1'b1;
                            if (exp_q[k].size() > 0) void'(exp_q[k].pop_back());
                        end
                        exp_q[k].push_back(word);
                        held[k] = word;  m_valid[k] = 1'b1;
                        nbits[k] = 0;  acc[k] = '0;
                    end
                end
            end
        end
    end

    // Monitor: status every cycle, and each consumed word against the scoreboard.
    logic [31:0] popped;
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            check("data_valid", k, 32'(valid[k]), 32'(m_valid[k]));
            check("overrun",    k, 32'(ovr[k]),   32'(m_ovr[k]));
            check("bit_cnt",    k, cnt[k],        32'(nbits[k]));
            check("busy",       k, 32'(busy[k]),  32'(nbits[k] != 0));
            check("data_out",   k, dout[k],       held[k]);
            if (rst_n && data_ack && valid[k]) begin
                check("sb_depth", k, 32'(exp_q[k].size()), 32'd1);
                if (exp_q[k].size() > 0) begin
                    popped = exp_q[k].pop_front();
                    check("sb_word", k, dout[k], popped);
                end
            end
        end
    end

    task automatic step(input bit sh, input bit din, input bit clr, input bit ack);
        shift = sh;  data_in = din;  clear = clr;  data_ack = ack;
        @(posedge clk);
        #1;
        shift = 1'b0;  clear = 1'b0;  data_ack = 1'b0;
    endtask

    task automatic send12(input logic [11:0] w, input bit msb, input bit ack_last);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, msb ? w[11-i] : w[i], 1'b0, (i == 11) && ack_last);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] msb_bits;
        rst_n = 1'b0;  data_in = 1'b0;  shift = 1'b0;  clear = 1'b0;  data_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 0, 32'(valid[0]), 32'd0);
        check("reset_dout",  0, dout[0],       32'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // LSB-first 0xA5C
        send12(12'hA5C, 1'b0, 1'b0);
        check("t1_dout",  0, dout[0],       32'hA5C);
        check("t1_valid", 0, 32'(valid[0]), 32'd1);
        check("t1_cnt",   0, cnt[0],        32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // MSB-first bit list of 0xA5C, busy through strobes 1..11
        msb_bits = 12'b1010_0101_1100;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, msb_bits[11-i], 1'b0, 1'b0);
            if (i < 11) check("t2_busy", 1, 32'(busy[1]), 32'd1);
        end
        check("t2_dout", 1, dout[1],      32'hA5C);
        check("t2_busy_end", 1, 32'(busy[1]), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun, then clear
        send12(12'h111, 1'b0, 1'b0);
        send12(12'h222, 1'b0, 1'b0);
        check("t3_ovr",   0, 32'(ovr[0]),   32'd1);
        check("t3_dout",  0, dout[0],       32'h222);
        check("t3_valid", 0, 32'(valid[0]), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_clr_ovr",   0, 32'(ovr[0]),   32'd0);
        check("t3_clr_valid", 0, 32'(valid[0]), 32'd1);

        // Completion together with ack
        send12(12'h333, 1'b0, 1'b1);
        check("t4_dout",  0, dout[0],       32'h333);
        check("t4_valid", 0, 32'(valid[0]), 32'd1);
        check("t4_ovr",   0, 32'(ovr[0]),   32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Clear beats a same-cycle shift
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("t5_cnt", 0, cnt[0], 32'd0);
        for (int i = 0; i < 11; i++) step(1'b1, 1'(12'h123 >> i), 1'b0, 1'b0);
        check("t5_no_early", 0, 32'(valid[0]), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_dout",  0, dout[0],       32'h123);
        check("t5_valid", 0, 32'(valid[0]), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-frame
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("t6_rst_dout",  0, dout[0],       32'd0);
        check("t6_rst_valid", 0, 32'(valid[0]), 32'd0);
        check("t6_rst_cnt",   0, cnt[0],        32'd0);
        check("t6_rst_busy",  0, 32'(busy[0]),  32'd0);
        check("t6_rst_ovr",   0, 32'(ovr[0]),   32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        send12(12'hFFF, 1'b0, 1'b0);
        check("t6_dout", 0, dout[0], 32'hFFF);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Randomised traffic, including back-to-back strobes and one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            if (c == 1700) begin
                rst_n = 1'b0;
                step(1'b0, 1'b0, 1'b0, 1'b0);
                rst_n = 1'b1;
            end
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0);
        end

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
